rdata_stream_demux: RTL and testbench

- Parametrised AXI read-data demultiplexer; successor to the fixed three-FIFO read-data splitter in the encoder read path.
- After each `start_pulse`, the first HDR_BEATS beats form a configuration header. They are captured into a flat register exposed to downstream decode logic.
- All later beats arrive in groups of NUM_CH beats; beat k of a group is routed to channel k's FIFO.
- Adds per-channel backpressure over all channels, sticky response-error capture, rlast/beat-count protocol checking and group counting.

---
 rtl/rdata_stream_demux.sv | 107 ++++++++++
 tb/tb_rdata_stream_demux.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdata_stream_demux.sv
// rtl/rdata_stream_demux.sv - AXI read-data demux: header capture, then payload beats dealt round-robin to NUM_CH FIFOs
module rdata_stream_demux #(
    parameter int DATA_WIDTH = 1024,
    parameter int ID_WIDTH   = 2,
    parameter int NUM_CH     = 3,
    parameter int HDR_BEATS  = 1,
    parameter int GRP_CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [ID_WIDTH-1:0]             m_axi_rid,
    input  logic                            m_axi_rlast,
    input  logic                            m_axi_rvalid,
    input  logic [1:0]                      m_axi_rresp,
    output logic                            m_axi_rready,
    input  logic                            start_pulse,
    output logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_data,
    output logic                            hdr_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]    ch_fifo_din,
    output logic [NUM_CH-1:0]               ch_fifo_wr,
    input  logic [NUM_CH-1:0]               ch_fifo_full,
    output logic [GRP_CNT_W-1:0]            grp_count,
    output logic                            rd_error,
    output logic [1:0]                      rd_error_resp,
    output logic                            proto_error
);
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_BEATS - 1);
    localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic {ST_HDR, ST_PAY} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] stage [NUM_CH];
    logic                  data_receive;
    logic                  at_last;
    logic                  unused_rid;

    assign unused_rid = ^m_axi_rid;

    // A group only starts when every FIFO has room; as sole writer, that room persists mid-group.
    assign m_axi_rready = (state == ST_HDR) || (idx != '0) || ~|ch_fifo_full;
    assign data_receive = m_axi_rvalid & m_axi_rready;
    assign at_last      = (state == ST_HDR) ? (idx == HDR_LAST) : (idx == PAY_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_HDR;
            idx           <= '0;
            hdr_data      <= '0;
            hdr_valid     <= 1'b0;
            ch_fifo_din   <= '0;
            ch_fifo_wr    <= '0;
            grp_count     <= '0;
            rd_error      <= 1'b0;
            rd_error_resp <= 2'b00;
            proto_error   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) stage[k] <= '0;
        end else begin
            ch_fifo_wr <= '0;
            if (start_pulse) begin
                state         <= ST_HDR;
                idx           <= '0;
                hdr_valid     <= 1'b0;
                grp_count     <= '0;
                rd_error      <= 1'b0;
                rd_error_resp <= 2'b00;
                proto_error   <= 1'b0;
                for (int k = 0; k < NUM_CH; k++) stage[k] <= '0;
            end else if (data_receive) begin
                if (m_axi_rresp != 2'b00 && !rd_error) begin
                    rd_error      <= 1'b1;
                    rd_error_resp <= m_axi_rresp;
                end
                if (m_axi_rlast != at_last) proto_error <= 1'b1;

                if (state == ST_HDR) begin
                    for (int h = 0; h < HDR_BEATS; h++)
                        if (idx == IDX_W'(h)) hdr_data[h*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                    if (at_last) begin
                        state     <= ST_PAY;
                        idx       <= '0;
                        hdr_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end else begin
                    for (int k = 0; k < NUM_CH; k++)
                        if (idx == IDX_W'(k)) stage[k] <= m_axi_rdata;
                    if (at_last) begin
                        // The final beat bypasses staging so the whole group lands in one edge.
                        for (int k = 0; k < NUM_CH; k++)
                            ch_fifo_din[k*DATA_WIDTH +: DATA_WIDTH] <=
                                (idx == IDX_W'(k)) ? m_axi_rdata : stage[k];
                        ch_fifo_wr <= '1;
                        grp_count  <= grp_count + GRP_CNT_W'(1);
                        idx        <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rdata_stream_demux.sv
// tb/tb_rdata_stream_demux.sv - scoreboard bench for rdata_stream_demux (3ch/1hdr random, 5ch/2hdr directed)
module tb_rdata_stream_demux;
    localparam int DW = 32;
    localparam int AN = 3;
    localparam int AH = 1;
    localparam int BN = 5;
    localparam int BH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    a_rdata = '0;
    logic [1:0]       a_rid = '0;
    logic             a_rlast = 1'b0, a_rvalid = 1'b0, a_start = 1'b0;
    logic [1:0]       a_rresp = '0;
    logic             a_rready;
    logic [AH*DW-1:0] a_hdr;
    logic             a_hdr_valid;
    logic [AN*DW-1:0] a_din;
    logic [AN-1:0]    a_wr;
    logic [AN-1:0]    a_full = '0;
    logic [15:0]      a_grp;
    logic             a_rd_err, a_proto;
    logic [1:0]       a_rd_resp;

    logic [DW-1:0]    b_rdata = '0;
    logic [1:0]       b_rid = '0;
    logic             b_rlast = 1'b0, b_rvalid = 1'b0, b_start = 1'b0;
    logic [1:0]       b_rresp = '0;
    logic             b_rready;
    logic [BH*DW-1:0] b_hdr;
    logic             b_hdr_valid;
    logic [BN*DW-1:0] b_din;
    logic [BN-1:0]    b_wr;
    logic [BN-1:0]    b_full = '0;
    logic [15:0]      b_grp;
    logic             b_rd_err, b_proto;
    logic [1:0]       b_rd_resp;

    rdata_stream_demux #(.DATA_WIDTH(DW), .ID_WIDTH(2), .NUM_CH(AN), .HDR_BEATS(AH), .GRP_CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .m_axi_rdata(a_rdata), .m_axi_rid(a_rid), .m_axi_rlast(a_rlast),
        .m_axi_rvalid(a_rvalid), .m_axi_rresp(a_rresp), .m_axi_rready(a_rready), .start_pulse(a_start),
        .hdr_data(a_hdr), .hdr_valid(a_hdr_valid), .ch_fifo_din(a_din), .ch_fifo_wr(a_wr),
        .ch_fifo_full(a_full), .grp_count(a_grp), .rd_error(a_rd_err), .rd_error_resp(a_rd_resp),
        .proto_error(a_proto));

    rdata_stream_demux #(.DATA_WIDTH(DW), .ID_WIDTH(2), .NUM_CH(BN), .HDR_BEATS(BH), .GRP_CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .m_axi_rdata(b_rdata), .m_axi_rid(b_rid), .m_axi_rlast(b_rlast),
        .m_axi_rvalid(b_rvalid), .m_axi_rresp(b_rresp), .m_axi_rready(b_rready), .start_pulse(b_start),
        .hdr_data(b_hdr), .hdr_valid(b_hdr_valid), .ch_fifo_din(b_din), .ch_fifo_wr(b_wr),
        .ch_fifo_full(b_full), .grp_count(b_grp), .rd_error(b_rd_err), .rd_error_resp(b_rd_resp),
        .proto_error(b_proto));

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [AN*DW-1:0] din;
        logic [15:0]      grp;
        time              t;
    } grp_exp_t;
    grp_exp_t a_q[$];
    grp_exp_t mon_e;

    // Reference model: absolute beat count since the last restart decides everything.
    int            m_pos;
    logic          m_hv, m_rde, m_pe;
    logic [1:0]    m_rdr;
    logic [15:0]   m_grp;
    logic [AH*DW-1:0] m_hdr;
    logic [DW-1:0] m_stage[$];

    task automatic model_clear();
        m_pos = 0; m_hv = 0; m_rde = 0; m_pe = 0; m_rdr = 0; m_grp = 0;
        m_stage.delete();
    endtask

    function automatic bit a_exp_rdy();
        if (m_pos < AH) return 1'b1;
        return ((m_pos - AH) % AN != 0) || (a_full == '0);
    endfunction

    function automatic bit a_exp_last();
        if (m_pos < AH) return m_pos == AH - 1;
        return (m_pos - AH) % AN == AN - 1;
    endfunction

    task automatic a_check_state();
        check("a_hdr_valid", a_hdr_valid, m_hv);
        check("a_hdr_data", a_hdr, m_hdr);
        check("a_rd_error", a_rd_err, m_rde);
        check("a_rd_error_resp", a_rd_resp, m_rdr);
        check("a_proto_error", a_proto, m_pe);
        check("a_grp_count", a_grp, m_grp);
    endtask

    task automatic a_beat(input logic [DW-1:0] d, input bit last, input logic [1:0] resp,
                          input logic [AN-1:0] full, input bit start);
        int waited;
        grp_exp_t e;
        waited = 0;
        @(negedge clk);
        a_rdata = d; a_rlast = last; a_rresp = resp; a_full = full; a_rvalid = 1'b1; a_start = start;
        #1;
        check("a_rready", a_rready, a_exp_rdy());
        while (!a_exp_rdy() && waited < 3) begin
            @(negedge clk);
            waited++;
            if (waited >= 2) a_full = '0;
            #1;
            check("a_rready_hold", a_rready, a_exp_rdy());
        end
        @(posedge clk);
        if (start) begin
            model_clear();
        end else begin
            if (last != a_exp_last()) m_pe = 1'b1;
            if (resp != 2'b00 && !m_rde) begin m_rde = 1'b1; m_rdr = resp; end
            if (m_pos < AH) begin
                m_hdr[m_pos*DW +: DW] = d;
                if (m_pos == AH - 1) m_hv = 1'b1;
            end else begin
                m_stage.push_back(d);
                if (m_stage.size() == AN) begin
                    for (int k = 0; k < AN; k++) e.din[k*DW +: DW] = m_stage[k];
                    m_grp = m_grp + 16'd1;
                    e.grp = m_grp;
                    e.t = $time;
                    a_q.push_back(e);
                    m_stage.delete();
                end
            end
            m_pos++;
        end
        #1;
        a_rvalid = 1'b0; a_start = 1'b0; a_rlast = 1'b0; a_rresp = 2'b00;
        a_check_state();
    endtask

    always @(negedge clk) begin
        if (rst_n && a_wr !== '0) begin
            if (a_q.size() == 0) begin
                n_checks++;
                $display("FAIL a_strobe: got unexpected strobe %b expected none", a_wr);
            end else begin
                mon_e = a_q.pop_front();
                check("a_strobe", a_wr, {AN{1'b1}});
                check("a_din", a_din, mon_e.din);
                check("a_strobe_grp", a_grp, mon_e.grp);
                check("a_strobe_latency", $time, mon_e.t + 5);
            end
        end
    end

    logic [BN*DW-1:0] b_exp[2];
    int b_g = 0;
    always @(negedge clk) begin
        if (rst_n && b_wr !== '0) begin
            if (b_g < 2) begin
                check("b_strobe", b_wr, {BN{1'b1}});
                check("b_din", b_din, b_exp[b_g]);
            end else begin
                n_checks++;
                $display("FAIL b_strobe: got unexpected strobe %b expected none", b_wr);
            end
            b_g++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bv[12];
        logic [AN-1:0] f;
        logic [1:0]    rs;
        bit            st, ls;

        model_clear();
        m_hdr = '0;
        #12;
        check("rst_hdr_valid", a_hdr_valid, 1'b0);
        check("rst_wr", a_wr, '0);
        check("rst_din", a_din, '0);
        check("rst_grp", a_grp, '0);
        check("rst_errors", {a_rd_err, a_rd_resp, a_proto}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // header then A,B,C
        a_beat(32'h1111_0000, 1, 2'b00, 3'b000, 0);
        a_beat(32'hAAAA_AAAA, 0, 2'b00, 3'b000, 0);
        a_beat(32'hBBBB_BBBB, 0, 2'b00, 3'b000, 0);
        a_beat(32'hCCCC_CCCC, 1, 2'b00, 3'b000, 0);
        // backpressure at group start
        a_beat(32'h0000_0001, 0, 2'b00, 3'b010, 0);
        a_beat(32'h0000_0002, 0, 2'b00, 3'b000, 0);
        a_beat(32'h0000_0003, 1, 2'b00, 3'b000, 0);
        // sticky response error keeps the first code
        a_beat(32'h0000_0010, 0, 2'b00, 3'b000, 0);
        a_beat(32'h0000_0011, 0, 2'b10, 3'b000, 0);
        a_beat(32'h0000_0012, 1, 2'b11, 3'b000, 0);
        a_beat(32'hDEAD_0000, 0, 2'b00, 3'b000, 1);
        // early rlast
        a_beat(32'h2222_0000, 1, 2'b00, 3'b000, 0);
        a_beat(32'h0000_0020, 1, 2'b00, 3'b000, 0);
        a_beat(32'h0000_0021, 0, 2'b00, 3'b000, 0);
        a_beat(32'h0000_0022, 1, 2'b00, 3'b000, 0);
        // restart coinciding with a header beat
        a_beat(32'hDEAD_0001, 0, 2'b00, 3'b000, 1);
        a_beat(32'hDEAD_0002, 1, 2'b00, 3'b000, 1);
        a_beat(32'h3333_0000, 1, 2'b00, 3'b000, 0);

        for (int n = 0; n < 160; n++) begin
            st = ($urandom % 30) == 0;
            f  = (!st && ($urandom % 3) == 0) ? AN'($urandom) : '0;
            rs = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
            ls = a_exp_last() ^ (($urandom % 12) == 0);
            a_beat($urandom, ls, rs, f, st);
        end

        // reset in the middle of a group drops it silently
        a_beat(32'h4444_0000, 0, 2'b00, 3'b000, 1);
        a_beat(32'h4444_0001, 1, 2'b00, 3'b000, 0);
        a_beat(32'h4444_0002, 0, 2'b00, 3'b000, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        m_hdr = '0;
        a_check_state();
        check("midrst_wr", a_wr, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // five channels, two header beats
        for (int i = 0; i < 12; i++) bv[i] = $urandom;
        b_exp[0] = {bv[6], bv[5], bv[4], bv[3], bv[2]};
        b_exp[1] = {bv[11], bv[10], bv[9], bv[8], bv[7]};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b_rdata = bv[i];
            b_rvalid = 1'b1;
            b_rlast = (i == 1) || (i == 6) || (i == 11);
            #1;
            check("b_rready", b_rready, 1'b1);
        end
        @(negedge clk);
        b_rvalid = 1'b0;
        b_rlast = 1'b0;
        repeat (3) @(negedge clk);
        check("b_groups", b_g, 2);
        check("b_grp_count", b_grp, 16'd2);
        check("b_hdr_data", b_hdr, {bv[1], bv[0]});
        check("b_hdr_valid", b_hdr_valid, 1'b1);
        check("b_errors", {b_rd_err, b_proto}, 2'b00);
        check("a_queue_empty", a_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
